// File: rtl/fp_div_sqrt_arb_unit_pkg.sv
// Shared types and default build constants for the FP divide/sqrt arbitration unit.
package fp_div_sqrt_arb_unit_pkg;

  localparam int ID_W             = 4;
  localparam int DEFAULT_FLEN     = 32;
  localparam int DEFAULT_DIV_LAT  = 8;
  localparam int DEFAULT_SQRT_LAT = 6;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic {
    SRC_DIV  = 1'b0,
    SRC_SQRT = 1'b1
  } src_e;

endpackage

// File: rtl/fp_div_sqrt_arb_unit_pipe.sv
// fp_valid_id_pipe: ce-gated {valid, id} shift register shadowing one fixed-latency core.
module fp_valid_id_pipe
  import fp_div_sqrt_arb_unit_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_adv,
  input  logic i_in_valid,
  input  id_t  i_in_id,
  output logic o_tail_valid,
  output id_t  o_tail_id
);

  logic [DEPTH-1:0] r_valid;
  id_t              r_id [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_adv) begin
      r_valid[0] <= i_in_valid;
      for (int i = 1; i < DEPTH; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  // ids follow the valids but need no reset
  always_ff @(posedge clk) begin
    if (i_adv) begin
      r_id[0] <= i_in_id;
      for (int i = 1; i < DEPTH; i++) r_id[i] <= r_id[i-1];
    end
  end

  assign o_tail_valid = r_valid[DEPTH-1];
  assign o_tail_id    = r_id[DEPTH-1];

endmodule

// File: rtl/fp_div_sqrt_arb_unit.sv
// FP div/sqrt front end: input stage, two tracking pipes, arbiter and writeback register.
// Define FP_DIV_SQRT_RR_ARB_EN for round-robin arbitration; default is fixed div priority.
module fp_div_sqrt_arb_unit
  import fp_div_sqrt_arb_unit_pkg::*;
#(
  parameter int FLEN     = DEFAULT_FLEN,
  parameter int DIV_LAT  = DEFAULT_DIV_LAT,
  parameter int SQRT_LAT = DEFAULT_SQRT_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FLEN-1:0] i_issue_rs1,
  input  logic [FLEN-1:0] i_issue_rs2,
  input  logic            i_issue_sqrt,
  input  logic            i_issue_new_request,
  input  id_t             i_issue_id,
  output logic            o_issue_ready,
  output logic            o_wb_done,
  output id_t             o_wb_id,
  output logic [FLEN-1:0] o_wb_rd,
  input  logic            i_wb_ack,
  output logic            o_div_ce,
  output logic [FLEN-1:0] o_div_x,
  output logic [FLEN-1:0] o_div_y,
  input  logic [FLEN-1:0] i_div_r,
  output logic            o_sqrt_ce,
  output logic [FLEN-1:0] o_sqrt_x,
  input  logic [FLEN-1:0] i_sqrt_r
);

  typedef logic [FLEN-1:0] fp_t;

  logic r_in_valid;
  logic r_in_sqrt;
  id_t  r_in_id;
  fp_t  r_in_rs1;
  fp_t  r_in_rs2;

  logic r_out_valid;
  id_t  r_out_id;
  fp_t  r_out_rd;

  logic w_div_adv, w_sqrt_adv;
  logic w_div_tail_valid, w_sqrt_tail_valid;
  id_t  w_div_tail_id, w_sqrt_tail_id;
  logic w_div_taken, w_sqrt_taken;
  logic w_div_wins;
  logic w_out_adv;

  // readiness follows the pipe the held op targets, not the incoming op
  assign o_issue_ready = !r_in_valid || (r_in_sqrt ? w_sqrt_adv : w_div_adv);

  always_ff @(posedge clk) begin
    if (rst) r_in_valid <= 1'b0;
    else if (o_issue_ready) r_in_valid <= i_issue_new_request;
  end

  always_ff @(posedge clk) begin
    if (o_issue_ready) begin
      r_in_sqrt <= i_issue_sqrt;
      r_in_id   <= i_issue_id;
      r_in_rs1  <= i_issue_rs1;
      r_in_rs2  <= i_issue_rs2;
    end
  end

  fp_valid_id_pipe #(.DEPTH(DIV_LAT)) u_div_pipe (
    .clk          (clk),
    .rst          (rst),
    .i_adv        (w_div_adv),
    .i_in_valid   (r_in_valid && !r_in_sqrt),
    .i_in_id      (r_in_id),
    .o_tail_valid (w_div_tail_valid),
    .o_tail_id    (w_div_tail_id)
  );

  fp_valid_id_pipe #(.DEPTH(SQRT_LAT)) u_sqrt_pipe (
    .clk          (clk),
    .rst          (rst),
    .i_adv        (w_sqrt_adv),
    .i_in_valid   (r_in_valid && r_in_sqrt),
    .i_in_id      (r_in_id),
    .o_tail_valid (w_sqrt_tail_valid),
    .o_tail_id    (w_sqrt_tail_id)
  );

`ifdef FP_DIV_SQRT_RR_ARB_EN
  src_e r_last;
  logic w_conflict;

  assign w_conflict = w_div_tail_valid && w_sqrt_tail_valid && w_out_adv;
  assign w_div_wins = (r_last == SRC_SQRT);

  // only real conflicts move the last-winner pointer
  always_ff @(posedge clk) begin
    if (rst) r_last <= SRC_DIV;
    else if (w_conflict) r_last <= w_div_wins ? SRC_DIV : SRC_SQRT;
  end
`else
  assign w_div_wins = 1'b1;

  if (DIV_LAT < SQRT_LAT) begin : g_lat_chk
    $error("fixed div priority requires DIV_LAT >= SQRT_LAT");
  end
`endif

  assign w_out_adv    = !r_out_valid || i_wb_ack;
  assign w_div_taken  = w_out_adv && w_div_tail_valid && (!w_sqrt_tail_valid || w_div_wins);
  assign w_sqrt_taken = w_out_adv && w_sqrt_tail_valid && (!w_div_tail_valid || !w_div_wins);
  assign w_div_adv    = !w_div_tail_valid || w_div_taken;
  assign w_sqrt_adv   = !w_sqrt_tail_valid || w_sqrt_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_rd    <= '0;
    end else if (w_out_adv) begin
      r_out_valid <= w_div_taken || w_sqrt_taken;
      if (w_div_taken) begin
        r_out_id <= w_div_tail_id;
        r_out_rd <= i_div_r;
      end else if (w_sqrt_taken) begin
        r_out_id <= w_sqrt_tail_id;
        r_out_rd <= i_sqrt_r;
      end
    end
  end

  assign o_wb_done = r_out_valid;
  assign o_wb_id   = r_out_id;
  assign o_wb_rd   = r_out_rd;
  assign o_div_ce  = w_div_adv;
  assign o_div_x   = r_in_rs1;
  assign o_div_y   = r_in_rs2;
  assign o_sqrt_ce = w_sqrt_adv;
  assign o_sqrt_x  = r_in_rs1;

endmodule
